// File: rtl/mul16_pkg.sv
// Widths, latency and the result-record type shared by the multiplier issue scheduler.
// Carries no logic; imported by the interface, the scheduler and its result FIFO.
package mul16_pkg;

    localparam int OPERAND_W   = 16;
    localparam int PRODUCT_W   = 36;
    localparam int MUL_LATENCY = 3;

    // The multiplier presents its 32-bit product in out[32:1].
    localparam int CAP_LSB = 1;
    localparam int CAP_W   = 32;

    // Sized for the largest supported requester count (8).
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0]  id;
        logic [PRODUCT_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/mul16_issue_scheduler_if.sv
// Request and response handshake bundle of the multiplier issue scheduler.
// master = requesters/consumer side, slave = scheduler side.
interface mul16_issue_scheduler_if
    import mul16_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*OPERAND_W-1:0] req_a;
    logic [NUM_REQ*OPERAND_W-1:0] req_b;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [ID_W-1:0]              resp_id;
    logic [PRODUCT_W-1:0]         resp_data;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/mul16_mult_model.sv
// Behavioural 3-register 16x16 multiplier; product appears left-shifted by one in out[32:1].
// Latency 3 cycles from A/B to out; cannot stall.
module Bit16Multiplier_Pipelined (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [35:0] out
);
    logic [31:0] s0_q, s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s0_q <= 32'(A) * 32'(B);
            s1_q <= s0_q;
            s2_q <= s1_q;
        end
    end

    assign out = {3'b000, s2_q, 1'b0};

endmodule

// File: rtl/mul16_result_fifo.sv
// Result FIFO with a registered head; a write into an empty FIFO is visible the next cycle.
// Latency 1 write-to-head; no write-side backpressure (caller guarantees space via credits).
module mul16_result_fifo
    import mul16_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_vld_i,
    input  resp_t wr_dat_i,
    input  logic  rd_rdy_i,
    output logic  rd_vld_o,
    output resp_t rd_dat_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    resp_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             out_vld_q;
    resp_t            out_dat_q;
    logic             pop, slot_free, from_mem, direct, mem_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop       = out_vld_q && rd_rdy_i;
    assign slot_free = !out_vld_q || pop;
    assign from_mem  = slot_free && (mem_cnt_q != '0);
    // Head register loads the write directly only when nothing older is queued.
    assign direct    = slot_free && (mem_cnt_q == '0) && wr_vld_i;
    assign mem_wr    = wr_vld_i && !direct;

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        if (mem_wr && !from_mem) begin
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end else if (!mem_wr && from_mem) begin
            mem_cnt_d = mem_cnt_q - CNT_W'(1);
        end
        occ_d = occ_q;
        if (wr_vld_i && !pop) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!wr_vld_i && pop) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            occ_q     <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            occ_q     <= occ_d;
            if (mem_wr) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (from_mem) begin
                out_dat_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= ptr_inc(rd_ptr_q);
            end else if (direct) begin
                out_dat_q <= wr_dat_i;
            end
            if (slot_free) begin
                out_vld_q <= from_mem || direct;
            end
        end
    end

    assign rd_vld_o = out_vld_q;
    assign rd_dat_o = out_dat_q;
    assign full_o   = (occ_q == CNT_W'(DEPTH));
    assign empty_o  = (occ_q == '0);

endmodule

// File: rtl/mul16_issue_scheduler.sv
// Round-robin sharing of one pipelined multiplier; products return in issue order via a result FIFO.
// Issue-to-resp_valid 4 cycles; req_ready drops when FIFO_DEPTH products are unpopped (credit backpressure).
module mul16_issue_scheduler
    import mul16_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = MUL_LATENCY,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    mul16_issue_scheduler_if.slave bus,
    output logic [OPERAND_W-1:0]   mul_a_o,
    output logic [OPERAND_W-1:0]   mul_b_o,
    input  logic [PRODUCT_W-1:0]   mul_p_i,
    output logic                   busy_o,
    output logic                   ovf_err_o
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [LATENCY-1:0] tag_vld_q;
    logic [ID_W-1:0]    tag_id_q [LATENCY];
    logic               ovf_q, ovf_d;

    logic               issue_ok, gnt_vld, pop, cap_vld;
    logic [ID_W-1:0]    gnt_idx, cand_id;
    int                 cand;
    resp_t              wr_dat, fifo_dat;
    logic               fifo_vld, fifo_full, fifo_empty;
    logic               unused_bits;

    assign issue_ok = (cnt_q < CNT_W'(FIFO_DEPTH)) && !reset;

    // Search starts one past the last winner and wraps.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        cand_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_id = ID_W'(cand);
            if (issue_ok && !gnt_vld && bus.req_valid[cand_id]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand_id;
            end
        end
    end

    assign bus.req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign mul_a_o = gnt_vld ? bus.req_a[int'(gnt_idx)*OPERAND_W +: OPERAND_W] : '0;
    assign mul_b_o = gnt_vld ? bus.req_b[int'(gnt_idx)*OPERAND_W +: OPERAND_W] : '0;

    assign pop    = fifo_vld && bus.resp_ready;
    assign last_d = gnt_vld ? gnt_idx : last_q;

    always_comb begin
        cnt_d = cnt_q;
        if (gnt_vld && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!gnt_vld && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign cap_vld = tag_vld_q[LATENCY-1];
    assign wr_dat  = '{id:   ID_MAX_W'(tag_id_q[LATENCY-1]),
                       data: {{(PRODUCT_W-CAP_W){1'b0}}, mul_p_i[CAP_LSB +: CAP_W]}};
    assign ovf_d   = ovf_q || (cap_vld && (mul_p_i[PRODUCT_W-1:CAP_LSB+CAP_W] != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            tag_vld_q <= '0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            ovf_q        <= ovf_d;
            tag_vld_q[0] <= gnt_vld;
            tag_id_q[0]  <= gnt_idx;
            for (int k = 1; k < LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    // Credits make this unreachable; firing means the counter and FIFO disagree.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(cap_vld && fifo_full));
        end
    end

    mul16_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_vld_i (cap_vld),
        .wr_dat_i (wr_dat),
        .rd_rdy_i (bus.resp_ready),
        .rd_vld_o (fifo_vld),
        .rd_dat_o (fifo_dat),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign bus.resp_valid = fifo_vld;
    assign bus.resp_id    = fifo_dat.id[ID_W-1:0];
    assign bus.resp_data  = fifo_dat.data;
    assign busy_o         = (cnt_q != '0) || (tag_vld_q != '0) || !fifo_empty;
    assign ovf_err_o      = ovf_q;
    assign unused_bits    = ^{mul_p_i[0], fifo_dat.id};

endmodule

// File: tb/tb_mul16_issue_scheduler.sv
// Directed bench for mul16_issue_scheduler with the multiplier model and an in-order scoreboard.
module tb_mul16_issue_scheduler;
    import mul16_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mul_a, mul_b;
    logic [35:0] mul_p;
    logic        busy, ovf_err;

    always #5 clk = ~clk;

    mul16_issue_scheduler_if #(.NUM_REQ(N)) bus ();

    mul16_issue_scheduler #(
        .NUM_REQ    (N),
        .LATENCY    (3),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mul_a_o   (mul_a),
        .mul_b_o   (mul_b),
        .mul_p_i   (mul_p),
        .busy_o    (busy),
        .ovf_err_o (ovf_err)
    );

    Bit16Multiplier_Pipelined u_mul (
        .clk   (clk),
        .reset (reset),
        .A     (mul_a),
        .B     (mul_b),
        .out   (mul_p)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [39:0] exp_q [$];
    int          mcnt  = 0;
    int          mlast = N - 1;
    int          acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
    endtask

    // Mid-cycle: predict the grant, record issues, and score any pop against the expected order.
    task automatic sample();
        logic [N-1:0] eg;
        int           cand;
        int           idx;
        logic [39:0]  head;
        @(negedge clk);
        eg  = '0;
        idx = 0;
        if (!reset && mcnt < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                cand = (mlast + k) % N;
                if (eg == '0 && bus.req_valid[cand]) begin
                    eg  = N'(1) << cand;
                    idx = cand;
                end
            end
        end
        check("req_ready", 64'(bus.req_ready), 64'(eg));
        if (eg != '0) begin
            exp_q.push_back({4'(idx), 36'(bus.req_a[idx*16 +: 16]) * 36'(bus.req_b[idx*16 +: 16])});
            mlast = idx;
            mcnt++;
        end
        if (bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_resp", 64'(bus.resp_valid), 64'(0));
            end else begin
                head = exp_q.pop_front();
                check("resp_id", 64'(bus.resp_id), 64'(head[39:36]));
                check("resp_data", 64'(bus.resp_data), 64'(head[35:0]));
            end
            mcnt--;
        end
        if (reset) begin
            exp_q.delete();
            mcnt  = 0;
            mlast = N - 1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        logic [N-1:0] rr_exp;

        // Reset state, with every requester asking
        reset          = 1'b1;
        bus.req_valid  = 4'hF;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_lane(i, 16'(10 + i), 16'(20 + i));
        advance();
        sample();
        check("rst_mul_a", 64'(mul_a), 64'(0));
        check("rst_mul_b", 64'(mul_b), 64'(0));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_resp_id", 64'(bus.resp_id), 64'(0));
        check("rst_resp_data", 64'(bus.resp_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ovf", 64'(ovf_err), 64'(0));
        advance();
        reset = 1'b0;

        // Round robin from requester 0, one grant per cycle
        for (int k = 0; k < 8; k++) begin
            rr_exp = 4'b0001 << (k % 4);
            sample();
            check("rr_grant", 64'(bus.req_ready), 64'(rr_exp));
            check("rr_mul_a", 64'(mul_a), 64'(10 + k % 4));
            check("rr_mul_b", 64'(mul_b), 64'(20 + k % 4));
            advance();
        end
        bus.req_valid = '0;
        for (int k = 0; k < 8; k++) step();
        check("rr_drained", 64'(exp_q.size()), 64'(0));

        // Single request: requester 2, 3*5
        set_lane(2, 16'd3, 16'd5);
        bus.req_valid = 4'b0100;
        sample();
        check("single_grant", 64'(bus.req_ready), 64'(4'b0100));
        check("single_mul_a", 64'(mul_a), 64'(3));
        check("single_mul_b", 64'(mul_b), 64'(5));
        advance();
        bus.req_valid = '0;
        for (int d = 1; d <= 3; d++) begin
            sample();
            check("single_early_valid", 64'(bus.resp_valid), 64'(0));
            advance();
        end
        sample();
        check("single_valid_t4", 64'(bus.resp_valid), 64'(1));
        check("single_id", 64'(bus.resp_id), 64'(2));
        check("single_data", 64'(bus.resp_data), 64'(15));
        check("single_busy_t4", 64'(busy), 64'(1));
        advance();
        sample();
        check("single_busy_t5", 64'(busy), 64'(0));
        check("single_valid_t5", 64'(bus.resp_valid), 64'(0));
        advance();

        // Largest operands on requester 1
        set_lane(1, 16'hFFFF, 16'hFFFF);
        bus.req_valid = 4'b0010;
        sample();
        check("max_grant", 64'(bus.req_ready), 64'(4'b0010));
        advance();
        bus.req_valid = '0;
        for (int d = 1; d <= 3; d++) step();
        sample();
        check("max_valid", 64'(bus.resp_valid), 64'(1));
        check("max_id", 64'(bus.resp_id), 64'(1));
        check("max_data", 64'(bus.resp_data), 64'(36'h0FFFE0001));
        check("max_ovf", 64'(ovf_err), 64'(0));
        advance();
        step();

        // Back-pressure: exactly DEPTH accepts with the consumer stalled
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0001;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            set_lane(0, 16'(100 + k), 16'd3);
            sample();
            if (bus.req_ready[0]) acc++;
            check("bp_ready", 64'(bus.req_ready), 64'((k < 8) ? 1 : 0));
            advance();
        end
        check("bp_accepts", 64'(acc), 64'(8));
        bus.resp_ready = 1'b1;
        set_lane(0, 16'd200, 16'd3);
        sample();
        check("bp_pop_valid", 64'(bus.resp_valid), 64'(1));
        check("bp_ready_at_pop", 64'(bus.req_ready), 64'(0));
        advance();
        set_lane(0, 16'd201, 16'd3);
        sample();
        check("bp_ready_after_pop", 64'(bus.req_ready), 64'(1));
        advance();
        bus.req_valid = '0;
        for (int k = 0; k < 14; k++) step();
        check("bp_drained", 64'(exp_q.size()), 64'(0));

        // Pop and issue together at DEPTH-1 outstanding leaves the count unchanged
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            set_lane(0, 16'(300 + k), 16'd7);
            step();
        end
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) step();
        bus.req_valid  = 4'b0001;
        bus.resp_ready = 1'b1;
        set_lane(0, 16'd400, 16'd7);
        sample();
        check("sim_issue", 64'(bus.req_ready), 64'(1));
        check("sim_pop", 64'(bus.resp_valid), 64'(1));
        advance();
        bus.resp_ready = 1'b0;
        set_lane(0, 16'd401, 16'd7);
        sample();
        check("sim_one_credit_left", 64'(bus.req_ready), 64'(1));
        advance();
        sample();
        check("sim_credits_out", 64'(bus.req_ready), 64'(0));
        advance();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 14; k++) step();
        check("sim_drained", 64'(exp_q.size()), 64'(0));

        // Random traffic against the scoreboard
        for (int c = 0; c < 100; c++) begin
            bus.req_valid  = 4'($urandom_range(0, 15));
            bus.req_a      = {$urandom(), $urandom()};
            bus.req_b      = {$urandom(), $urandom()};
            bus.resp_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        check("rand_drained", 64'(exp_q.size()), 64'(0));

        // Reset with three products in flight and two buffered
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'hF;
        for (int i = 0; i < N; i++) set_lane(i, 16'(50 + i), 16'(60 + i));
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        sample();
        check("rst_mid_buffered", 64'(bus.resp_valid), 64'(1));
        check("rst_mid_mul_a", 64'(mul_a), 64'(0));
        advance();
        reset          = 1'b0;
        bus.resp_ready = 1'b1;
        sample();
        check("post_rst_valid", 64'(bus.resp_valid), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_grant", 64'(bus.req_ready), 64'(4'b0001));
        advance();
        bus.req_valid = '0;
        for (int k = 0; k < 10; k++) step();
        check("post_rst_drained", 64'(exp_q.size()), 64'(0));
        check("final_busy", 64'(busy), 64'(0));
        check("final_ovf", 64'(ovf_err), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
